// File: rtl/uart_send64_pkg.sv
// Shared definitions for the 64-bit UART loop: serialiser state encoding,
// frame geometry and the clocks-per-bit derivation used by both directions.
package uart_send64_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_e;

  localparam int unsigned BYTES_PER_FRAME = 8;
  localparam int unsigned BITS_PER_BYTE   = 8;

  function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                               input int unsigned uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single 8N1 byte serialiser. A start accepted in the final stop-bit clock
// chains straight into the next start bit, so bytes go out with no idle gap.
module uart_byte_tx
  import uart_send64_pkg::*;
#(
  parameter int unsigned BPS_CNT = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       start,
  input  logic [7:0] data,
  output logic       txd,
  output logic       done
);

  localparam int unsigned      CNT_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BPS_CNT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(BITS_PER_BYTE - 1);

  tx_state_e        state_q, state_d;
  logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             txd_q, txd_d;
  logic             bit_end;

  assign bit_end = (baud_cnt_q == CNT_MAX);
  assign done    = (state_q == STOP) && bit_end;
  assign txd     = txd_q;

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path through the case
    // leaves a signal unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    txd_d      = txd_q;

    if (state_q != IDLE) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = START;
          txd_d      = 1'b0;
          shift_d    = data;
          bit_idx_d  = '0;
          baud_cnt_d = '0;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == LAST_BIT) begin
            state_d = STOP;
            txd_d   = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          bit_idx_d = '0;
          if (start) begin
            state_d = START;
            txd_d   = 1'b0;
            shift_d = data;
          end else begin
            state_d = IDLE;
            txd_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others, independent of statement order.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      txd_q      <= txd_d;
    end
  end

endmodule

// File: rtl/uart_send64.sv
// 64-bit UART transmitter: captures a word on each send_en rising edge and
// sends it as eight 8N1 bytes, MSB byte first, holding tx_busy for the frame.
module uart_send64
  import uart_send64_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned UART_BPS = 115200
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        send_en,
  input  logic [63:0] send_data,
  output logic        tx_busy,
  output logic        uart_txd
);

  localparam int unsigned BPS_CNT   = calc_bps_cnt(CLK_FREQ, UART_BPS);
  localparam logic [2:0]  LAST_BYTE = 3'(BYTES_PER_FRAME - 1);

  logic        en_d0_q, en_d1_q;
  logic        tx_busy_q, tx_busy_d;
  logic [63:0] frame_q, frame_d;
  logic [2:0]  byte_idx_q, byte_idx_d;

  logic        start_flag;
  logic        frame_start;
  logic        next_byte;
  logic        byte_start;
  logic        byte_done;
  logic [7:0]  byte_data;

  assign start_flag  = en_d0_q & ~en_d1_q;
  assign frame_start = start_flag & ~tx_busy_q;
  assign next_byte   = tx_busy_q & byte_done & (byte_idx_q != LAST_BYTE);
  assign byte_start  = frame_start | next_byte;

  // The first byte bypasses the frame register so its start bit begins on the
  // same edge that captures the word; later bytes come from the rotated copy.
  assign byte_data = frame_start ? send_data[63:56] : frame_q[55:48];

  always_comb begin
    frame_d    = frame_q;
    byte_idx_d = byte_idx_q;
    tx_busy_d  = tx_busy_q;
    if (frame_start) begin
      frame_d    = send_data;
      byte_idx_d = '0;
      tx_busy_d  = 1'b1;
    end else if (next_byte) begin
      frame_d    = {frame_q[55:0], frame_q[63:56]};
      byte_idx_d = byte_idx_q + 3'd1;
    end else if (tx_busy_q && byte_done) begin
      tx_busy_d  = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_d0_q    <= 1'b0;
      en_d1_q    <= 1'b0;
      tx_busy_q  <= 1'b0;
      frame_q    <= '0;
      byte_idx_q <= '0;
    end else begin
      en_d0_q    <= send_en;
      en_d1_q    <= en_d0_q;
      tx_busy_q  <= tx_busy_d;
      frame_q    <= frame_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  uart_byte_tx #(
    .BPS_CNT (BPS_CNT)
  ) u_byte_tx (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .start     (byte_start),
    .data      (byte_data),
    .txd       (uart_txd),
    .done      (byte_done)
  );

  assign tx_busy = tx_busy_q;

endmodule
